// File: rtl/counter_uart_reporter_pkg.sv
// Shared types, ASCII constants and nibble-to-hex mapping for the counter UART reporter.
package counter_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'h0, n}) : (ASCII_A_OFS + {4'h0, n});
  endfunction

endpackage

// File: rtl/counter_uart_reporter_tx_byte.sv
// 8N1 byte serializer: start, 8 data bits LSB first, stop, each held CLK_DIV cycles.
module uart_tx_byte
  import counter_uart_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  localparam int            BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud == BAUD_LAST);
  // Ready also during the final stop cycle so the next byte starts with no gap.
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state <= START;
            shreg <= data;
            tx    <= 1'b0;
            baud  <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            done <= 1'b1;
            baud <= '0;
            if (load) begin
              state <= START;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/counter_uart_reporter.sv
// Latches a 16-bit sample and reports it over UART as 4 hex digits, optionally followed by CR LF.
module counter_uart_reporter
  import counter_uart_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int         NBYTES   = SEND_CRLF ? 6 : 4;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  logic [15:0] latch;
  logic [2:0]  byte_idx;
  logic        accept;
  logic        next_byte;
  logic        tx_load;
  logic        tx_ready;
  logic        tx_done;
  logic [7:0]  tx_data;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] v);
    case (idx)
      3'd0:    return nibble_to_ascii(v[15:12]);
      3'd1:    return nibble_to_ascii(v[11:8]);
      3'd2:    return nibble_to_ascii(v[7:4]);
      3'd3:    return nibble_to_ascii(v[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign sample_ready = ~busy;
  assign accept       = sample_valid & sample_ready & ~rst;
  assign next_byte    = busy & tx_ready & (byte_idx != LAST_IDX);
  assign tx_load      = accept | next_byte;
  // The first byte comes straight from the input because the latch only updates at the accept edge.
  assign tx_data      = busy ? frame_byte(byte_idx + 3'd1, latch) : frame_byte(3'd0, sample_data);
  // The serializer only reports done with busy already cleared after the last stop bit.
  assign frame_done   = tx_done & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      byte_idx <= '0;
      latch    <= '0;
    end else if (accept) begin
      busy     <= 1'b1;
      byte_idx <= '0;
      latch    <= sample_data;
    end else if (busy && tx_ready) begin
      if (byte_idx == LAST_IDX) begin
        busy <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .data (tx_data),
    .ready(tx_ready),
    .tx   (tx),
    .done (tx_done)
  );

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Bench: three reporter instances (div 4 + CRLF, div 4 digits only, div 2 + CRLF), scoreboarded UART decode.
module tb_counter_uart_reporter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sdata  [3];
  logic        svalid [3];
  int          checks = 0;
  int          errors = 0;
  int          qsize    [3];
  bit          mon_idle [3];

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int DIV  = (g == 2) ? 2 : 4;
    localparam bit CRLF = (g != 1);
    localparam int NB   = CRLF ? 6 : 4;
    localparam int L    = 10 * NB * DIV;

    logic tx, busy, frame_done, sample_ready;

    counter_uart_reporter #(
      .CLK_DIV  (DIV),
      .SEND_CRLF(CRLF)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_data (sdata[g]),
      .sample_valid(svalid[g]),
      .sample_ready(sample_ready),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done)
    );

    logic [7:0] q[$];
    bit         mbusy = 1'b0;
    bit         mdone = 1'b0;
    bit         rst_q = 1'b1;
    int         mcnt  = 0;

    // Reference: a frame of L cycles per accepted sample; its characters go to the queue.
    always @(posedge clk) begin
      rst_q = rst;
      mdone = 1'b0;
      if (rst) begin
        mbusy = 1'b0;
      end else if (!mbusy) begin
        if (svalid[g]) begin
          mbusy = 1'b1;
          mcnt  = 0;
          for (int i = 3; i >= 0; i--) q.push_back(hex_char(int'((sdata[g] >> (4 * i)) & 16'hF)));
          if (CRLF) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
          end
        end
      end else begin
        mcnt++;
        if (mcnt == L) begin
          mbusy = 1'b0;
          mdone = 1'b1;
        end
      end
    end

    int         bitn = -1;
    int         cyc  = 0;
    logic       cur;
    logic [7:0] shv;
    logic [7:0] e;

    always @(negedge clk) begin
      chk(busy === mbusy, "busy", int'(busy), int'(mbusy));
      chk(sample_ready === !mbusy, "sample_ready", int'(sample_ready), int'(!mbusy));
      chk(frame_done === mdone, "frame_done", int'(frame_done), int'(mdone));
      if (!mbusy) chk(tx === 1'b1, "tx_idle", int'(tx), 1);
      if (rst_q) begin
        bitn = -1;
        q.delete();
      end else if (bitn < 0) begin
        if (tx === 1'b0) begin
          bitn = 0;
          cyc  = 1;
          cur  = 1'b0;
        end
      end else begin
        if (cyc == DIV) begin
          bitn++;
          cyc = 1;
          cur = tx;
          if (bitn <= 8) shv[bitn-1] = tx;
          else chk(tx === 1'b1, "stop_bit", int'(tx), 1);
        end else begin
          cyc++;
          chk(tx === cur, "bit_hold", int'(tx), int'(cur));
        end
        if (bitn == 9 && cyc == DIV) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_byte", int'(shv), 0);
          end else begin
            e = q.pop_front();
            chk(shv === e, "byte", int'(shv), int'(e));
          end
          bitn = -1;
        end
      end
      qsize[g]    = q.size();
      mon_idle[g] = (bitn < 0);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      svalid[i] = 1'b1;
      sdata[i]  = 16'h0000;
    end
    sdata[0] = 16'h1A2F;
    sdata[1] = 16'hFFFF;
    sdata[2] = 16'h8000;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) svalid[i] = 1'b0;
    tick(250);

    // Valid held across two frames with data changing mid-frame.
    sdata[0]  = 16'h0000;
    svalid[0] = 1'b1;
    tick(51);
    sdata[0] = 16'h9BC3;
    tick(191);
    svalid[0] = 1'b0;
    tick(250);

    // Reset during byte 3, data bit 2, then a fresh frame.
    sdata[0]  = 16'h5555;
    svalid[0] = 1'b1;
    tick(1);
    svalid[0] = 1'b0;
    tick(92);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    sdata[0]  = 16'h0007;
    svalid[0] = 1'b1;
    tick(1);
    svalid[0] = 1'b0;
    tick(250);

    repeat (6) begin
      for (int i = 0; i < 3; i++) begin
        sdata[i]  = 16'($urandom);
        svalid[i] = 1'b1;
      end
      tick(1);
      for (int i = 0; i < 3; i++) svalid[i] = 1'b0;
      tick(245 + $urandom_range(0, 10));
    end

    svalid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sdata[0] = 16'($urandom);
      tick(37);
    end
    svalid[0] = 1'b0;
    tick(260);

    for (int i = 0; i < 3; i++) begin
      chk(qsize[i] == 0, "queue_drained", qsize[i], 0);
      chk(mon_idle[i], "monitor_idle", int'(mon_idle[i]), 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
